univ_shift_reg: RTL and testbench

//  Parametrised universal shift register: the next generation of our 4-bit right-shift register.

---
 rtl/usr_pkg.sv | 15 +
 rtl/usr_shift_cnt.sv | 41 ++++
 rtl/univ_shift_reg.sv | 62 ++++++
 tb/tb_univ_shift_reg.sv | 254 +++++++++++++++++++++++++
 4 files changed

// File: rtl/usr_pkg.sv
// Shared constants for the universal shift register.
package usr_pkg;

  // Operating modes selected by the 2-bit mode input.
  localparam logic [1:0] MODE_HOLD = 2'b00;
  localparam logic [1:0] MODE_SHR  = 2'b01;
  localparam logic [1:0] MODE_SHL  = 2'b10;
  localparam logic [1:0] MODE_LOAD = 2'b11;

  // True for either shift direction; both advance the shift counter.
  function automatic logic is_shift(input logic [1:0] m);
    return (m == MODE_SHR) || (m == MODE_SHL);
  endfunction

endpackage

// File: rtl/usr_shift_cnt.sv
// Saturating shift counter with a registered one-cycle "word done" pulse.
// cnt counts shifts since the last load or reset and sticks at WIDTH;
// done fires only on the edge that takes cnt from WIDTH-1 to WIDTH.
module usr_shift_cnt #(
  parameter int WIDTH = 4,
  parameter int CNT_W = $clog2(WIDTH + 1)
) (
  input  logic             clk,
  input  logic             clr,
  input  logic             en,
  input  logic             inc,
  input  logic             ld,
  output logic [CNT_W-1:0] cnt,
  output logic             done
);

  localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(WIDTH);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

  // Counter and done pulse; done defaults low so any edge that is not the
  // WIDTH-th shift clears it. A load wins over an increment.
  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      cnt  <= '0;
      done <= 1'b0;
    end else begin
      done <= 1'b0;
      if (en) begin
        if (ld) begin
          cnt <= '0;
        end else if (inc && (cnt != CNT_MAX)) begin
          cnt <= cnt + 1'b1;
          if (cnt == CNT_LAST) begin
            done <= 1'b1;
          end
        end
      end
    end
  end

endmodule

// File: rtl/univ_shift_reg.sv
// Universal shift register: hold, shift right, shift left, parallel load,
// with clock enable and a shift counter for serializer/deserializer use.
module univ_shift_reg
  import usr_pkg::*;
#(
  parameter  int WIDTH = 4,
  localparam int CNT_W = $clog2(WIDTH + 1)
) (
  input  logic             clk,
  input  logic             clr,
  input  logic             en,
  input  logic [1:0]       mode,
  input  logic             SDR,
  input  logic             SDL,
  input  logic [WIDTH-1:0] D,
  output logic [WIDTH-1:0] Q,
  output logic             SOR,
  output logic             SOL,
  output logic [CNT_W-1:0] cnt,
  output logic             done
);

  logic [WIDTH-1:0] q_next;

  // Mode mux: right shift brings SDR in at the MSB, left shift brings SDL in at the LSB.
  always_comb begin
    q_next = Q;
    case (mode)
      MODE_HOLD: q_next = Q;
      MODE_SHR:  q_next = {SDR, Q[WIDTH-1:1]};
      MODE_SHL:  q_next = {Q[WIDTH-2:0], SDL};
      MODE_LOAD: q_next = D;
      default:   q_next = Q;
    endcase
  end

  // Data register; en=0 freezes it whatever the mode.
  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      Q <= '0;
    end else if (en) begin
      Q <= q_next;
    end
  end

  assign SOR = Q[0];
  assign SOL = Q[WIDTH-1];

  usr_shift_cnt #(
    .WIDTH (WIDTH),
    .CNT_W (CNT_W)
  ) u_cnt (
    .clk  (clk),
    .clr  (clr),
    .en   (en),
    .inc  (is_shift(mode)),
    .ld   (mode == MODE_LOAD),
    .cnt  (cnt),
    .done (done)
  );

endmodule

// File: tb/tb_univ_shift_reg.sv
// Directed bench for univ_shift_reg at WIDTH=4 and WIDTH=8.
module tb_univ_shift_reg;

  logic       clk;
  // WIDTH=4 instance
  logic       clr4, en4, sdr4, sdl4, sor4, sol4, done4;
  logic [1:0] mode4;
  logic [3:0] d4, q4;
  logic [2:0] cnt4;
  // WIDTH=8 instance
  logic       clr8, en8, sdr8, sdl8, sor8, sol8, done8;
  logic [1:0] mode8;
  logic [7:0] d8, q8;
  logic [3:0] cnt8;

  int n_checks = 0;
  int n_fail   = 0;

  univ_shift_reg #(.WIDTH(4)) dut4 (
    .clk(clk), .clr(clr4), .en(en4), .mode(mode4), .SDR(sdr4), .SDL(sdl4),
    .D(d4), .Q(q4), .SOR(sor4), .SOL(sol4), .cnt(cnt4), .done(done4)
  );

  univ_shift_reg #(.WIDTH(8)) dut8 (
    .clk(clk), .clr(clr8), .en(en8), .mode(mode8), .SDR(sdr8), .SDL(sdl8),
    .D(d8), .Q(q8), .SOR(sor8), .SOL(sol8), .cnt(cnt8), .done(done8)
  );

  // clock
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // driver tasks
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive4(input logic e, input logic [1:0] m, input logic r,
                        input logic l, input logic [3:0] d);
    en4 = e; mode4 = m; sdr4 = r; sdl4 = l; d4 = d;
  endtask

  task automatic drive8(input logic e, input logic [1:0] m, input logic r,
                        input logic l, input logic [7:0] d);
    en8 = e; mode8 = m; sdr8 = r; sdl8 = l; d8 = d;
  endtask

  task automatic test_reset();
    clr4 = 1'b1; clr8 = 1'b1;
    drive4(1'b1, 2'b11, 1'b1, 1'b1, 4'hF);
    drive8(1'b1, 2'b11, 1'b1, 1'b1, 8'hFF);
    #2;
    n_checks++;
    if ({q4, cnt4, done4} !== 8'b0) begin
      n_fail++; $display("FAIL reset4: got q=%b cnt=%0d done=%b, expected 0/0/0", q4, cnt4, done4);
    end
    n_checks++;
    if ({q8, cnt8, done8} !== 13'b0) begin
      n_fail++; $display("FAIL reset8: got q=%h cnt=%0d done=%b, expected 0/0/0", q8, cnt8, done8);
    end
    // reset held across an edge with load requested
    tick();
    n_checks++;
    if (q4 !== 4'b0000) begin
      n_fail++; $display("FAIL reset_held: got q=%b expected 0000", q4);
    end
    clr4 = 1'b0; clr8 = 1'b0;
    // load, then shift once so cnt is nonzero, then pulse clr mid-cycle
    drive4(1'b1, 2'b11, 1'b0, 1'b0, 4'b1010);
    tick();
    drive4(1'b1, 2'b01, 1'b1, 1'b0, 4'b0000);
    tick();
    n_checks++;
    if (q4 !== 4'b1101 || cnt4 !== 3'd1) begin
      n_fail++; $display("FAIL pre_clr: got q=%b cnt=%0d expected 1101/1", q4, cnt4);
    end
    #1 clr4 = 1'b1;
    #1;
    n_checks++;
    if ({q4, cnt4, done4} !== 8'b0) begin
      n_fail++; $display("FAIL async_clr: got q=%b cnt=%0d done=%b expected 0/0/0", q4, cnt4, done4);
    end
    #1 clr4 = 1'b0;
    drive4(1'b1, 2'b00, 1'b0, 1'b0, 4'b0000);
  endtask

  task automatic test_shift_right();
    logic [3:0] exp_q[$] = '{4'b1000, 4'b1100, 4'b1110, 4'b1111};
    logic [2:0] exp_c[$] = '{3'd1, 3'd2, 3'd3, 3'd4};
    logic       exp_d[$] = '{1'b0, 1'b0, 1'b0, 1'b1};
    drive4(1'b1, 2'b01, 1'b1, 1'b0, 4'b0101);  // SDL and D must be ignored
    for (int i = 0; i < 4; i++) begin
      tick();
      n_checks++;
      if (q4 !== exp_q[i] || cnt4 !== exp_c[i] || done4 !== exp_d[i]) begin
        n_fail++;
        $display("FAIL shr step %0d: got q=%b cnt=%0d done=%b expected q=%b cnt=%0d done=%b",
                 i + 1, q4, cnt4, done4, exp_q[i], exp_c[i], exp_d[i]);
      end
    end
    drive4(1'b1, 2'b00, 1'b0, 1'b0, 4'b0000);
    tick();
    n_checks++;
    if (q4 !== 4'b1111 || cnt4 !== 3'd4 || done4 !== 1'b0) begin
      n_fail++; $display("FAIL shr_hold: got q=%b cnt=%0d done=%b expected 1111/4/0", q4, cnt4, done4);
    end
  endtask

  task automatic test_shift_left();
    logic [3:0] exp_q[$]   = '{4'b0110, 4'b1100, 4'b1000, 4'b0000};
    logic       exp_sol[$] = '{1'b1, 1'b0, 1'b1, 1'b1};
    drive4(1'b1, 2'b11, 1'b0, 1'b0, 4'b1011);
    tick();
    n_checks++;
    if (q4 !== 4'b1011 || cnt4 !== 3'd0 || sor4 !== 1'b1 || sol4 !== 1'b1) begin
      n_fail++; $display("FAIL load: got q=%b cnt=%0d sor=%b sol=%b expected 1011/0/1/1", q4, cnt4, sor4, sol4);
    end
    drive4(1'b1, 2'b10, 1'b1, 1'b0, 4'b1111);  // SDR and D must be ignored
    for (int i = 0; i < 4; i++) begin
      n_checks++;
      if (sol4 !== exp_sol[i]) begin
        n_fail++; $display("FAIL shl_sol step %0d: got %b expected %b", i + 1, sol4, exp_sol[i]);
      end
      tick();
      n_checks++;
      if (q4 !== exp_q[i] || cnt4 !== 3'(i + 1) || done4 !== (i == 3)) begin
        n_fail++;
        $display("FAIL shl step %0d: got q=%b cnt=%0d done=%b expected q=%b cnt=%0d done=%b",
                 i + 1, q4, cnt4, done4, exp_q[i], i + 1, (i == 3));
      end
    end
  endtask

  task automatic test_enable();
    drive4(1'b1, 2'b11, 1'b0, 1'b0, 4'b1011);
    tick();
    drive4(1'b1, 2'b10, 1'b0, 1'b1, 4'b0000);  // one shift: 0111, cnt=1
    tick();
    drive4(1'b0, 2'b01, 1'b1, 1'b0, 4'b0000);
    for (int i = 0; i < 3; i++) begin
      tick();
      n_checks++;
      if (q4 !== 4'b0111 || cnt4 !== 3'd1 || done4 !== 1'b0) begin
        n_fail++; $display("FAIL en_hold step %0d: got q=%b cnt=%0d done=%b expected 0111/1/0", i + 1, q4, cnt4, done4);
      end
    end
    drive4(1'b0, 2'b11, 1'b0, 1'b0, 4'b1001);  // load also blocked
    tick();
    n_checks++;
    if (q4 !== 4'b0111 || cnt4 !== 3'd1) begin
      n_fail++; $display("FAIL en_load: got q=%b cnt=%0d expected 0111/1", q4, cnt4);
    end
  endtask

  task automatic test_saturate();
    logic [3:0] exp_q[$] = '{4'b0011, 4'b0001, 4'b0000, 4'b0000, 4'b0000, 4'b0000};
    logic [2:0] exp_c[$] = '{3'd1, 3'd2, 3'd3, 3'd4, 3'd4, 3'd4};
    logic       exp_d[$] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
    drive4(1'b1, 2'b11, 1'b0, 1'b0, 4'b0110);
    tick();
    drive4(1'b1, 2'b01, 1'b0, 1'b1, 4'b0000);
    for (int i = 0; i < 6; i++) begin
      tick();
      n_checks++;
      if (q4 !== exp_q[i] || cnt4 !== exp_c[i] || done4 !== exp_d[i]) begin
        n_fail++;
        $display("FAIL sat step %0d: got q=%b cnt=%0d done=%b expected q=%b cnt=%0d done=%b",
                 i + 1, q4, cnt4, done4, exp_q[i], exp_c[i], exp_d[i]);
      end
    end
    drive4(1'b1, 2'b11, 1'b0, 1'b0, 4'b1001);
    tick();
    n_checks++;
    if (q4 !== 4'b1001 || cnt4 !== 3'd0 || done4 !== 1'b0) begin
      n_fail++; $display("FAIL sat_reload: got q=%b cnt=%0d done=%b expected 1001/0/0", q4, cnt4, done4);
    end
  endtask

  task automatic test_mixed_dir();
    logic [1:0] modes[$] = '{2'b01, 2'b10, 2'b10, 2'b01};
    logic       sdr[$]   = '{1'b1, 1'b0, 1'b1, 1'b0};
    logic       sdl[$]   = '{1'b0, 1'b1, 1'b0, 1'b1};
    logic [3:0] exp_q[$] = '{4'b1000, 4'b0001, 4'b0010, 4'b0001};
    drive4(1'b1, 2'b11, 1'b0, 1'b0, 4'b0001);
    tick();
    for (int i = 0; i < 4; i++) begin
      drive4(1'b1, modes[i], sdr[i], sdl[i], 4'b1110);
      tick();
      n_checks++;
      if (q4 !== exp_q[i] || cnt4 !== 3'(i + 1) || done4 !== (i == 3)) begin
        n_fail++;
        $display("FAIL mixed step %0d: got q=%b cnt=%0d done=%b expected q=%b cnt=%0d done=%b",
                 i + 1, q4, cnt4, done4, exp_q[i], i + 1, (i == 3));
      end
    end
  endtask

  task automatic test_width8();
    logic       exp_sor[$] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1};
    logic [7:0] exp_q[$]   = '{8'h52, 8'h29, 8'h14, 8'h0A, 8'h05, 8'h02, 8'h01, 8'h00};
    drive8(1'b1, 2'b11, 1'b0, 1'b0, 8'hA5);
    tick();
    drive8(1'b1, 2'b01, 1'b0, 1'b1, 8'hFF);
    for (int i = 0; i < 8; i++) begin
      n_checks++;
      if (sor8 !== exp_sor[i]) begin
        n_fail++; $display("FAIL w8_sor step %0d: got %b expected %b", i + 1, sor8, exp_sor[i]);
      end
      tick();
      n_checks++;
      if (q8 !== exp_q[i] || cnt8 !== 4'(i + 1) || done8 !== (i == 7)) begin
        n_fail++;
        $display("FAIL w8 step %0d: got q=%h cnt=%0d done=%b expected q=%h cnt=%0d done=%b",
                 i + 1, q8, cnt8, done8, exp_q[i], i + 1, (i == 7));
      end
    end
    // clr mid-sequence
    drive8(1'b1, 2'b11, 1'b0, 1'b0, 8'hA5);
    tick();
    drive8(1'b1, 2'b01, 1'b0, 1'b0, 8'h00);
    tick(); tick(); tick();
    n_checks++;
    if (q8 !== 8'h14 || cnt8 !== 4'd3) begin
      n_fail++; $display("FAIL w8_pre_clr: got q=%h cnt=%0d expected 14/3", q8, cnt8);
    end
    #1 clr8 = 1'b1;
    #1;
    n_checks++;
    if (q8 !== 8'h00 || cnt8 !== 4'd0 || done8 !== 1'b0) begin
      n_fail++; $display("FAIL w8_clr: got q=%h cnt=%0d done=%b expected 00/0/0", q8, cnt8, done8);
    end
    #1 clr8 = 1'b0;
    drive8(1'b1, 2'b01, 1'b1, 1'b0, 8'h00);
    tick();
    n_checks++;
    if (q8 !== 8'h80 || cnt8 !== 4'd1 || done8 !== 1'b0) begin
      n_fail++; $display("FAIL w8_post_clr: got q=%h cnt=%0d done=%b expected 80/1/0", q8, cnt8, done8);
    end
  endtask

  initial begin
    test_reset();
    test_shift_right();
    test_shift_left();
    test_enable();
    test_saturate();
    test_mixed_dir();
    test_width8();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
